// File: rtl/mem_loader.sv
// mem_loader: streams noun-cell words from a valid/ready source into
// consecutive memory_unit addresses, then hands the root address to
// mem_traversal via a level start request.
module mem_loader #(
    parameter int         ADDR_W     = 16,
    parameter int         DATA_W     = 68,
    parameter int         CNT_W      = 16,
    parameter logic [1:0] FUNC_WRITE = 2'b01,
    parameter logic [1:0] FUNC_READ  = 2'b00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              power,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mem_ready,
    output logic              mem_execute,
    output logic [1:0]        mem_func,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              traversal_execute,
    output logic [ADDR_W-1:0] start_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_WORD,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   addr_q, addr_nx;
    logic [ADDR_W-1:0]   start_addr_q, start_addr_nx;
    logic [CNT_W-1:0]    remaining_q, remaining_nx, remaining_dec;
    logic [DATA_W-1:0]   data_q, data_nx;
    logic                overflow_q, overflow_nx;
    logic                trav_q, trav_nx;
    logic                done_q, done_nx;

    // Handshake and command strobe are decoded from state; power=0 masks them.
    assign in_ready          = power && (state == S_WAIT_WORD) && mem_ready;
    assign mem_execute       = power && (state == S_ISSUE);
    assign mem_func          = (state == S_ISSUE) ? FUNC_WRITE : FUNC_READ;
    assign mem_addr          = addr_q;
    assign mem_data          = data_q;
    assign busy              = (state == S_WAIT_WORD) || (state == S_ISSUE) ||
                               (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
    assign done              = done_q;
    assign overflow          = overflow_q;
    assign traversal_execute = trav_q;
    assign start_addr        = start_addr_q;

    // State and datapath registers; power=0 freezes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            addr_q       <= '0;
            start_addr_q <= '0;
            remaining_q  <= '0;
            data_q       <= '0;
            overflow_q   <= 1'b0;
            trav_q       <= 1'b0;
            done_q       <= 1'b0;
        end else if (power) begin
            state        <= state_nx;
            addr_q       <= addr_nx;
            start_addr_q <= start_addr_nx;
            remaining_q  <= remaining_nx;
            data_q       <= data_nx;
            overflow_q   <= overflow_nx;
            trav_q       <= trav_nx;
            done_q       <= done_nx;
        end
    end

    // Next-state and next-register logic for the load sequence.
    always_comb begin
        state_nx      = state;
        addr_nx       = addr_q;
        start_addr_nx = start_addr_q;
        remaining_nx  = remaining_q;
        data_nx       = data_q;
        overflow_nx   = overflow_q;
        trav_nx       = trav_q;
        done_nx       = 1'b0;
        remaining_dec = remaining_q - CNT_W'(1);

        case (state)
            S_IDLE: begin
                if (start) begin
                    addr_nx       = base_addr;
                    start_addr_nx = base_addr;
                    remaining_nx  = word_count;
                    overflow_nx   = 1'b0;
                    trav_nx       = 1'b0;
                    state_nx      = (word_count == '0) ? S_FINISH : S_WAIT_WORD;
                end
            end
            S_WAIT_WORD: begin
                if (in_valid && in_ready) begin
                    data_nx  = in_data;
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nx = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!mem_ready) begin
                    state_nx = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (mem_ready) begin
                    remaining_nx = remaining_dec;
                    if (remaining_dec == '0) begin
                        state_nx = S_FINISH;
                    end else if (addr_q == '1) begin
                        // Address would wrap: stop without consuming the rest.
                        overflow_nx = 1'b1;
                        state_nx    = S_FINISH;
                    end else begin
                        addr_nx  = addr_q + ADDR_W'(1);
                        state_nx = S_WAIT_WORD;
                    end
                end
            end
            S_FINISH: begin
                done_nx  = 1'b1;
                trav_nx  = !overflow_q;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader with a behavioural memory_unit model.
module tb_mem_loader;

    localparam int AW  = 8;
    localparam int DW  = 68;
    localparam int CW  = 16;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          power = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] word_count = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          mem_ready = 1'b1;
    logic          mem_execute;
    logic [1:0]    mem_func;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          busy, done, overflow, traversal_execute;
    logic [AW-1:0] start_addr;

    int checks = 0;
    int errors = 0;

    mem_loader #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW),
                 .FUNC_WRITE(2'b01), .FUNC_READ(2'b00)) dut (
        .clk(clk), .rst(rst), .power(power), .start(start),
        .base_addr(base_addr), .word_count(word_count),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_ready(mem_ready), .mem_execute(mem_execute), .mem_func(mem_func),
        .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy), .done(done),
        .overflow(overflow), .traversal_execute(traversal_execute),
        .start_addr(start_addr)
    );

    always #5 clk = ~clk;

    // memory_unit model: drops ready for LAT+1 cycles per command, writes on completion.
    logic [DW-1:0] mem [256];
    logic [AW-1:0] wr_addr [16];
    logic [DW-1:0] wr_data [16];
    int            exec_cnt = 0;
    int            lat = 0;
    logic          mem_clr = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_data = '0;
    logic          p_wr = 1'b0;
    int            ir_viol = 0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            exec_cnt <= 0;
        end else if (mem_execute) begin
            if (exec_cnt < 16) begin
                wr_addr[exec_cnt] <= mem_addr;
                wr_data[exec_cnt] <= mem_data;
            end
            exec_cnt  <= exec_cnt + 1;
            p_addr    <= mem_addr;
            p_data    <= mem_data;
            p_wr      <= (mem_func == 2'b01);
            mem_ready <= 1'b0;
            lat       <= LAT;
        end
        if (!mem_ready) begin
            if (lat == 0) begin
                mem_ready <= 1'b1;
                if (p_wr) mem[p_addr] <= p_data;
            end else begin
                lat <= lat - 1;
            end
        end
    end

    // Counts cycles where the loader offers ready while memory is busy.
    always @(negedge clk) begin
        if (in_ready && !mem_ready) ir_viol <= ir_viol + 1;
    end

    task automatic clear_mem();
        @(negedge clk) mem_clr = 1'b1;
        @(negedge clk) mem_clr = 1'b0;
    endtask

    task automatic pulse_start(input logic [AW-1:0] b, input logic [CW-1:0] n);
        @(negedge clk);
        start = 1'b1; base_addr = b; word_count = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one word, returns #1 after the accepting edge.
    task automatic send_word(input logic [DW-1:0] d, input int gap);
        bit ok;
        ok = 1'b0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1; in_data = d;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_word_timeout: in_ready=0 after 100 cycles, required 1");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    // Returns at the negedge where done is observed high.
    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL done_timeout: done=0 after 300 cycles, required 1");
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, mem_execute, busy, done, overflow, traversal_execute} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 000000",
                     {in_ready, mem_execute, busy, done, overflow, traversal_execute});
        end
        checks++;
        if (mem_func !== 2'b00 || mem_addr !== 8'h00 || mem_data !== 68'h0 || start_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_bus: func=%b addr=%h data=%h start_addr=%h required 00/00/0/00",
                     mem_func, mem_addr, mem_data, start_addr);
        end
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_back_to_back();
        clear_mem();
        ir_viol = 0;
        pulse_start(8'd1, 16'd3);
        send_word(68'h1, 0);
        checks++;
        if (mem_execute !== 1'b1 || mem_func !== 2'b01 || mem_addr !== 8'd1 || mem_data !== 68'h1) begin
            errors++;
            $display("FAIL b2b_issue: exec=%b func=%b addr=%h data=%h required 1/01/01/1",
                     mem_execute, mem_func, mem_addr, mem_data);
        end
        send_word(68'h2, 0);
        send_word(68'hDEADBEEF, 0);
        wait_done();
        checks++;
        if (exec_cnt !== 3) begin
            errors++;
            $display("FAIL b2b_exec_count: got %0d required 3", exec_cnt);
        end
        checks++;
        if (wr_addr[0] !== 8'd1 || wr_addr[1] !== 8'd2 || wr_addr[2] !== 8'd3) begin
            errors++;
            $display("FAIL b2b_addrs: got %h %h %h required 01 02 03", wr_addr[0], wr_addr[1], wr_addr[2]);
        end
        checks++;
        if (traversal_execute !== 1'b1 || start_addr !== 8'd1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_handoff: trav=%b start_addr=%h ovf=%b required 1/01/0",
                     traversal_execute, start_addr, overflow);
        end
        checks++;
        if (mem[1] !== 68'h1 || mem[2] !== 68'h2 || mem[3] !== 68'hDEADBEEF) begin
            errors++;
            $display("FAIL b2b_readback: got %h %h %h required 1 2 deadbeef", mem[1], mem[2], mem[3]);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || traversal_execute !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done_pulse: done=%b trav=%b required 0/1", done, traversal_execute);
        end
    endtask

    task automatic test_gapped();
        clear_mem();
        ir_viol = 0;
        pulse_start(8'd1, 16'd3);
        send_word(68'h1, 5);
        send_word(68'h2, 5);
        send_word(68'hDEADBEEF, 5);
        wait_done();
        checks++;
        if (exec_cnt !== 3 || mem[1] !== 68'h1 || mem[2] !== 68'h2 || mem[3] !== 68'hDEADBEEF) begin
            errors++;
            $display("FAIL gap_contents: exec=%0d mem=%h %h %h required 3 1 2 deadbeef",
                     exec_cnt, mem[1], mem[2], mem[3]);
        end
        checks++;
        if (ir_viol !== 0) begin
            errors++;
            $display("FAIL gap_ready_while_busy: got %0d cycles required 0", ir_viol);
        end
    endtask

    task automatic test_zero_count();
        clear_mem();
        pulse_start(8'd7, 16'd0);
        checks++;
        if (done !== 1'b0 || traversal_execute !== 1'b0) begin
            errors++;
            $display("FAIL zero_first_cycle: done=%b trav=%b required 0/0", done, traversal_execute);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || traversal_execute !== 1'b1 || exec_cnt !== 0 || start_addr !== 8'd7) begin
            errors++;
            $display("FAIL zero_done: done=%b trav=%b exec=%0d start_addr=%h required 1/1/0/07",
                     done, traversal_execute, exec_cnt, start_addr);
        end
    endtask

    task automatic test_overflow();
        bit bad;
        clear_mem();
        pulse_start(8'hFF, 16'd2);
        send_word(68'hA5, 0);
        in_valid = 1'b1; in_data = 68'hB6;
        wait_done();
        checks++;
        if (exec_cnt !== 1 || wr_addr[0] !== 8'hFF || mem[8'hFF] !== 68'hA5) begin
            errors++;
            $display("FAIL ovf_write: exec=%0d addr=%h data=%h required 1/ff/a5",
                     exec_cnt, wr_addr[0], mem[8'hFF]);
        end
        checks++;
        if (overflow !== 1'b1 || traversal_execute !== 1'b0) begin
            errors++;
            $display("FAIL ovf_flags: ovf=%b trav=%b required 1/0", overflow, traversal_execute);
        end
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (in_ready !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || exec_cnt !== 1) begin
            errors++;
            $display("FAIL ovf_after: in_ready_seen=%b exec=%0d required 0/1", bad, exec_cnt);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midload();
        bit ok;
        int base_cnt;
        clear_mem();
        pulse_start(8'd10, 16'd4);
        send_word(68'h111, 0);
        send_word(68'h222, 0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (exec_cnt == 2 && mem_ready) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_mid_wait: exec=%0d required 2", exec_cnt);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({in_ready, mem_execute, busy, done, overflow, traversal_execute} !== 6'b0 ||
            mem_func !== 2'b00 || mem_addr !== 8'h00 || mem_data !== 68'h0 || start_addr !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_outputs: flags=%b func=%b addr=%h data=%h sa=%h required 0s",
                     {in_ready, mem_execute, busy, done, overflow, traversal_execute},
                     mem_func, mem_addr, mem_data, start_addr);
        end
        checks++;
        if (mem[10] !== 68'h111 || mem[11] !== 68'h222) begin
            errors++;
            $display("FAIL rst_mid_kept: got %h %h required 111 222", mem[10], mem[11]);
        end
        @(negedge clk) rst = 1'b1;
        base_cnt = exec_cnt;
        pulse_start(8'd50, 16'd1);
        send_word(68'h333, 0);
        wait_done();
        checks++;
        if (exec_cnt !== base_cnt + 1 || mem[50] !== 68'h333 || traversal_execute !== 1'b1 ||
            start_addr !== 8'd50) begin
            errors++;
            $display("FAIL rst_fresh_load: exec=%0d mem=%h trav=%b sa=%h required %0d/333/1/32",
                     exec_cnt, mem[50], traversal_execute, start_addr, base_cnt + 1);
        end
    endtask

    task automatic test_power();
        bit ok, bad;
        clear_mem();
        pulse_start(8'd40, 16'd2);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        power = 1'b0;
        in_valid = 1'b1; in_data = 68'h444;
        start = 1'b1; base_addr = 8'd99; word_count = 16'd5;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || mem_execute !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (!ok || bad || exec_cnt !== 0 || busy !== 1'b1 || mem_addr !== 8'd40 || start_addr !== 8'd40) begin
            errors++;
            $display("FAIL power_freeze: reached=%b strobe_seen=%b exec=%0d busy=%b addr=%h sa=%h required 1/0/0/1/28/28",
                     ok, bad, exec_cnt, busy, mem_addr, start_addr);
        end
        power = 1'b1; start = 1'b0; in_valid = 1'b0;
        send_word(68'h444, 0);
        pulse_start(8'd99, 16'd5);
        send_word(68'h555, 0);
        wait_done();
        checks++;
        if (exec_cnt !== 2 || wr_addr[0] !== 8'd40 || wr_addr[1] !== 8'd41 ||
            mem[40] !== 68'h444 || mem[41] !== 68'h555) begin
            errors++;
            $display("FAIL power_load: exec=%0d addrs=%h %h data=%h %h required 2 28 29 444 555",
                     exec_cnt, wr_addr[0], wr_addr[1], mem[40], mem[41]);
        end
        checks++;
        if (start_addr !== 8'd40 || traversal_execute !== 1'b1) begin
            errors++;
            $display("FAIL power_busy_start: sa=%h trav=%b required 28/1", start_addr, traversal_execute);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gapped();
        test_zero_count();
        test_overflow();
        test_reset_midload();
        test_power();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
